sccb_slave_regs: RTL and testbench

- SCCB responder (camera-side register model) for the other end of the SCCB master link. It answers on the same scl/sda pair driven by the PS-controlled SCCB master.
- Decodes 3-phase write and 2-phase write + 2-phase read transactions and holds an internal 8-bit register bank.
- Reports every register write to fabric as a one-cycle strobe.
- Used as an in-fabric loopback target for bring-up and as a camera stand-in in simulation.

---
 rtl/sccb_slave_regs.sv | 163 ++++++++++++++++
 tb/tb_sccb_slave_regs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave_regs.sv
// SCCB responder with an internal 8-bit register bank; commits writes as one-cycle strobes.
// Optional macro SCCB_ACK_EN: drive the 9th (ACK) bit low on matching ID/SUB/WDATA phases.
module sccb_slave_regs #(
  parameter logic [6:0] SLAVE_ID    = 7'h21,
  parameter int         REG_AW      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       axi_clk,
  input  logic       axi_rst_n,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_wr,
  output logic [7:0] reg_waddr,
  output logic [7:0] reg_wdata,
  output logic       busy,
  output logic       id_miss
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ID, ST_SUB, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;

  localparam int DEPTH = 1 << REG_AW;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic [3:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic [7:0]             r_ptr;
  logic [7:0]             r_rd_byte;
  logic [7:0]             r_bank [DEPTH];
  logic                   r_sda_oe, r_reg_wr, r_id_miss;
  logic [7:0]             r_reg_waddr, r_reg_wdata;

  logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_bit_rise, w_active, w_last_bit, w_ninth, w_id_match;
  logic       w_wr_set, w_miss_set, w_drive, w_ack;
  logic [7:0] w_byte;
  logic [2:0] w_rd_idx;

  // Sync flops reset to the idle-bus level so releasing reset creates no edges.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = r_sda_d & ~w_sda & w_scl;
  assign w_stop     = ~r_sda_d & w_sda & w_scl;
  assign w_bit_rise = w_scl_rise & ~w_start & ~w_stop;
  assign w_active   = (r_state == ST_ID) || (r_state == ST_SUB) ||
                      (r_state == ST_WDATA) || (r_state == ST_RDATA);
  assign w_last_bit = w_bit_rise & w_active & (r_bit_cnt == 4'd7);
  assign w_ninth    = w_bit_rise & w_active & (r_bit_cnt == 4'd8);
  assign w_byte     = {r_shift, w_sda};
  assign w_id_match = (w_byte[7:1] == SLAVE_ID);
  assign w_rd_idx   = ~r_bit_cnt[2:0];

`ifdef SCCB_ACK_EN
  assign w_ack = (r_bit_cnt == 4'd8) &&
                 ((r_state == ST_ID) || (r_state == ST_SUB) || (r_state == ST_WDATA));
`else
  assign w_ack = 1'b0;
`endif

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Byte decisions happen on the 8th rise; phase changes wait for the 9th rise.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_set    = 1'b0;
    w_miss_set  = 1'b0;
    w_drive     = w_ack;
    if ((r_state == ST_RDATA) && (r_bit_cnt < 4'd8)) w_drive = ~r_rd_byte[w_rd_idx];
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_ID;
    end else begin
      case (r_state)
        ST_ID: begin
          if (w_last_bit && !w_id_match) begin
            w_state_nxt = ST_IGNORE;
            w_miss_set  = 1'b1;
          end else if (w_ninth) begin
            w_state_nxt = r_shift[0] ? ST_RDATA : ST_SUB;
          end
        end
        ST_SUB:   if (w_ninth) w_state_nxt = ST_WDATA;
        ST_WDATA: begin
          w_wr_set = w_last_bit;
          if (w_ninth) w_state_nxt = ST_IGNORE;
        end
        ST_RDATA: if (w_ninth) w_state_nxt = ST_IGNORE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rd_byte   <= '0;
      r_sda_oe    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_id_miss   <= 1'b0;
      r_reg_waddr <= '0;
      r_reg_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      r_reg_wr  <= w_wr_set;
      r_id_miss <= w_miss_set;
      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else begin
        if (w_bit_rise && w_active) begin
          if (r_bit_cnt == 4'd8) begin
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_shift   <= w_byte[6:0];
          end
        end
        if ((r_state == ST_SUB) && w_last_bit) r_ptr <= w_byte;
        if (w_wr_set) begin
          r_bank[r_ptr[REG_AW-1:0]] <= w_byte;
          r_reg_waddr               <= r_ptr;
          r_reg_wdata               <= w_byte;
        end
        if ((r_state == ST_ID) && w_ninth) r_rd_byte <= r_bank[r_ptr[REG_AW-1:0]];
        if (w_scl_fall) r_sda_oe <= w_drive;
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_wr    = r_reg_wr;
  assign reg_waddr = r_reg_waddr;
  assign reg_wdata = r_reg_wdata;
  assign id_miss   = r_id_miss;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave_regs.sv
// Scoreboard bench for sccb_slave_regs: a bus-master model issues SCCB transactions and
// queues expected strobes/read bytes; a monitor pops and compares when the DUT presents them.
module tb_sccb_slave_regs;

`ifdef SCCB_ACK_EN
  localparam logic ACK_ON = 1'b1;
`else
  localparam logic ACK_ON = 1'b0;
`endif

  localparam logic [1:0] K_WR = 2'd0, K_MISS = 2'd1, K_RD = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic       axi_clk = 1'b0;
  logic       axi_rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe, reg_wr, busy, id_miss;
  logic [7:0] reg_waddr, reg_wdata;

  int   checks = 0;
  int   errors = 0;
  ev_t  sb_q[$];
  logic rd_valid = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  logic oe_seen = 1'b0;

  assign sda_i = sda_m & ~sda_oe;

  sccb_slave_regs dut (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n), .scl(scl), .sda_i(sda_i),
    .sda_oe(sda_oe), .reg_wr(reg_wr), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .busy(busy), .id_miss(id_miss)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d addr=%0h data=%0h expected=none", kind, a, d);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      chk("sb_addr", 32'(a), 32'(e.a));
      chk("sb_data", 32'(d), 32'(e.d));
    end
  endtask

  always @(negedge axi_clk) begin
    if (axi_rst_n) begin
      if (sda_oe) oe_seen = 1'b1;
      if (reg_wr)   pop_cmp(K_WR, reg_waddr, reg_wdata);
      if (id_miss)  pop_cmp(K_MISS, 8'h00, 8'h00);
      if (rd_valid) pop_cmp(K_RD, 8'h00, rd_byte);
    end
  end

  task automatic q();
    repeat (8) @(posedge axi_clk);
    #1;
  endtask

  task automatic send_start();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic send_stop();
    sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic wbyte(input logic [7:0] v, input logic exp_ack, input string name);
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    sda_m = 1'b1; q(); scl = 1'b1; q();
    chk(name, 32'(sda_oe), 32'(exp_ack));
    q(); scl = 1'b0; q();
  endtask

  task automatic write3(input logic [7:0] sub, input logic [7:0] data);
    sb_q.push_back('{kind: K_WR, a: sub, d: data});
    send_start();
    wbyte(8'h42, ACK_ON, "ack_id_w");
    wbyte(sub, ACK_ON, "ack_sub");
    wbyte(data, ACK_ON, "ack_data");
    send_stop();
  endtask

  task automatic write2(input logic [7:0] sub);
    send_start();
    wbyte(8'h42, ACK_ON, "ack_id_w");
    wbyte(sub, ACK_ON, "ack_sub");
    send_stop();
  endtask

  task automatic read_byte(input logic [7:0] exp);
    logic [7:0] b;
    sb_q.push_back('{kind: K_RD, a: 8'h00, d: exp});
    send_start();
    wbyte(8'h43, ACK_ON, "ack_id_r");
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; q(); scl = 1'b1; q(); b[i] = sda_i; q(); scl = 1'b0; q();
    end
    q(); scl = 1'b1; q();
    chk("na_release", 32'(sda_oe), 32'd0);
    q(); scl = 1'b0; q();
    send_stop();
    @(posedge axi_clk); #1 rd_byte = b; rd_valid = 1'b1;
    @(posedge axi_clk); #1 rd_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_waddr", 32'(reg_waddr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id_miss", 32'(id_miss), 32'd0);
    axi_rst_n = 1'b1;
    q();

    // 3-phase write
    oe_seen = 1'b0;
    write3(8'h12, 8'h80);
    q();
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("write_oe_any", 32'(oe_seen), 32'(ACK_ON));

    // read back reset value, then written value
    write2(8'h0A);
    read_byte(8'h00);
    write3(8'h0A, 8'h76);
    read_byte(8'h76);

    // wrong ID
    oe_seen = 1'b0;
    sb_q.push_back('{kind: K_MISS, a: 8'h00, d: 8'h00});
    send_start();
    q();
    chk("busy_mid_txn", 32'(busy), 32'd1);
    wbyte(8'h60, 1'b0, "ack_bad_id");
    wbyte(8'h12, 1'b0, "ack_ign_sub");
    wbyte(8'h55, 1'b0, "ack_ign_data");
    send_stop();
    q();
    chk("bad_id_oe_any", 32'(oe_seen), 32'd0);

    // repeated start mid sub byte
    sb_q.push_back('{kind: K_WR, a: 8'h05, d: 8'h3C});
    send_start();
    wbyte(8'h42, ACK_ON, "ack_id_w");
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    send_start();
    wbyte(8'h42, ACK_ON, "ack_id_w");
    wbyte(8'h05, ACK_ON, "ack_sub");
    wbyte(8'h3C, ACK_ON, "ack_data");
    send_stop();
    read_byte(8'h3C);
    write2(8'h12);
    read_byte(8'h80);

    // reset during RDATA bit 3 of 0x76 (a 0 bit, so the slave is pulling)
    write2(8'h0A);
    send_start();
    wbyte(8'h43, ACK_ON, "ack_id_r");
    for (int i = 0; i < 4; i++) begin
      sda_m = 1'b1; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    end
    sda_m = 1'b1; q(); scl = 1'b1; q();
    chk("rd_bit3_driven", 32'(sda_oe), 32'd1);
    axi_rst_n = 1'b0;
    #1;
    chk("rst_async_oe", 32'(sda_oe), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    q();
    axi_rst_n = 1'b1;
    scl = 1'b0;
    q();
    send_stop();
    q();
    read_byte(8'h00);
    write2(8'h0A);
    read_byte(8'h00);

    q(); q();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
